// File: rtl/qam_symbol_mixer.sv
// qam_symbol_mixer
//   16-QAM modulator back end. Accepts 4-bit symbols over a valid/ready
//   handshake, holds each symbol for SPS samples, maps its two 2-bit fields to
//   I/Q levels {-3,-1,+1,+3} and mixes them with the incoming carrier pair:
//     mod = (I*carrier_i - Q*carrier_q) >>> OUT_SHIFT, one sample per clk.
//
// Build option
//   QAM_GRAY_MAP_EN  defined   : Gray level map   00->-3 01->-1 11->+1 10->+3
//                    undefined : natural level map 00->-3 01->-1 10->+1 11->+3
//
// Parameters
//   SPS        samples (clk cycles) per symbol, >= 2
//   OUT_SHIFT  arithmetic right shift applied to the mixed sum, >= 3
//
// Ports
//   clk        sample clock
//   rst        synchronous active-high reset
//   carrier_i  signed carrier I, bits [31:16] used
//   carrier_q  signed carrier Q, bits [31:16] used
//   sym_data   symbol: [3:2] I level select, [1:0] Q level select
//   sym_valid  sym_data valid
//   sym_ready  symbol accepted this cycle when sym_valid is also high
//   mod_out    {signed 16-bit modulated sample, 16'b0}, 2-cycle latency
//   busy       a symbol is being transmitted
//   underrun   one-cycle pulse: symbol period ended with no symbol waiting
module qam_symbol_mixer #(
  parameter int SPS       = 16,
  parameter int OUT_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] carrier_i,
  input  logic [31:0] carrier_q,
  input  logic [3:0]  sym_data,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [31:0] mod_out,
  output logic        busy,
  output logic        underrun
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic signed [2:0]  li_reg, lq_reg;
  logic signed [18:0] pi_reg, pq_reg;
  logic [31:0]        mod_reg;
  logic               busy_reg;
  logic               underrun_reg;

  logic               transfer;
  logic signed [18:0] ci_ext, cq_ext, li_ext, lq_ext;
  logic signed [18:0] pi_next, pq_next;
  logic signed [19:0] s_next, m_next;
  logic               unused_bits;

  function automatic logic signed [2:0] level_map(input logic [1:0] f);
    logic signed [2:0] lvl;
    lvl = 3'sb101;
`ifdef QAM_GRAY_MAP_EN
    case (f)
      2'b00: lvl = 3'sb101;  // -3
      2'b01: lvl = 3'sb111;  // -1
      2'b11: lvl = 3'sb001;  // +1
      2'b10: lvl = 3'sb011;  // +3
      default: lvl = 3'sb101;
    endcase
`else
    case (f)
      2'b00: lvl = 3'sb101;  // -3
      2'b01: lvl = 3'sb111;  // -1
      2'b10: lvl = 3'sb001;  // +1
      2'b11: lvl = 3'sb011;  // +3
      default: lvl = 3'sb101;
    endcase
`endif
    return lvl;
  endfunction

  // Ready in IDLE or on the last sample of a symbol; cnt stays 0 in IDLE.
  // Gated by rst so no symbol can be taken while reset is held.
  assign sym_ready = !rst && ((state_reg == IDLE) || (cnt_reg == CNT_LAST));
  assign transfer  = sym_valid && sym_ready;

  // Stage 1 operands, sign-extended to the 19-bit product width.
  assign ci_ext  = {{3{carrier_i[31]}}, carrier_i[31:16]};
  assign cq_ext  = {{3{carrier_q[31]}}, carrier_q[31:16]};
  assign li_ext  = {{16{li_reg[2]}}, li_reg};
  assign lq_ext  = {{16{lq_reg[2]}}, lq_reg};
  assign pi_next = ci_ext * li_ext;
  assign pq_next = cq_ext * lq_ext;

  // Stage 2: full-width difference, then floor shift; the result always fits
  // in 16 bits for OUT_SHIFT >= 3, so plain truncation is safe.
  assign s_next = {pi_reg[18], pi_reg} - {pq_reg[18], pq_reg};
  assign m_next = s_next >>> OUT_SHIFT;

  assign unused_bits = ^{carrier_i[15:0], carrier_q[15:0], m_next[19:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      li_reg       <= '0;
      lq_reg       <= '0;
      pi_reg       <= '0;
      pq_reg       <= '0;
      mod_reg      <= '0;
      busy_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      pi_reg       <= pi_next;
      pq_reg       <= pq_next;
      mod_reg      <= {m_next[15:0], 16'h0000};
      underrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            li_reg    <= level_map(sym_data[3:2]);
            lq_reg    <= level_map(sym_data[1:0]);
            cnt_reg   <= '0;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (transfer) begin
              li_reg <= level_map(sym_data[3:2]);
              lq_reg <= level_map(sym_data[1:0]);
            end else begin
              // Zero levels flush the datapath to 0 two cycles later.
              li_reg       <= '0;
              lq_reg       <= '0;
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              underrun_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mod_out  = mod_reg;
  assign busy     = busy_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_qam_symbol_mixer.sv
// Testbench for qam_symbol_mixer. A driver issues one input vector per cycle
// and pushes the hand-derived expected outputs for that cycle into a queue;
// a monitor pops one entry per cycle on the falling edge and compares.
// Expected mod values are precomputed constants for each level map build.
module tb_qam_symbol_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] carrier_i, carrier_q;
  logic [3:0]  sym_data;
  logic        sym_valid;
  logic        sym_ready;
  logic [31:0] mod_out;
  logic        busy;
  logic        underrun;

  qam_symbol_mixer #(.SPS(16), .OUT_SHIFT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .carrier_i(carrier_i),
    .carrier_q(carrier_q),
    .sym_data (sym_data),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .mod_out  (mod_out),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        bsy;
    logic        und;
    logic [31:0] mod;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  sym_list[$];
  logic [15:0] m_list[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mon_cycle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, mon_cycle, act, exp);
    end
  endtask

  // Monitor: one expected entry per driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sym_ready", {31'd0, sym_ready}, {31'd0, e.rdy});
      chk("busy",      {31'd0, busy},      {31'd0, e.bsy});
      chk("underrun",  {31'd0, underrun},  {31'd0, e.und});
      chk("mod_out",   mod_out,            e.mod);
      mon_cycle++;
    end
  end

  // One cycle: wait for the edge, drive new inputs, queue what the outputs
  // must show before the next edge (state after this edge, ready with new rst).
  task automatic cycle(input logic r, input logic v, input logic [3:0] s,
                       input logic [31:0] ci, input logic [31:0] cq,
                       input logic e_rdy, input logic e_bsy, input logic e_und,
                       input logic [31:0] e_mod);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    sym_valid = v;
    sym_data  = s;
    carrier_i = ci;
    carrier_q = cq;
    e.rdy = e_rdy;
    e.bsy = e_bsy;
    e.und = e_und;
    e.mod = e_mod;
    exp_q.push_back(e);
  endtask

  // Offers sym_list[0] from IDLE, then n back-to-back symbols from sym_list
  // with mod values m_list, then 4 idle cycles. Symbol k occupies cycles
  // 16k+1..16k+16 (cnt = 0..15); mod lags the levels by two cycles; the
  // underrun pulse is seen the cycle after the last symbol ends.
  // hold=1 keeps sym_valid high while not ready; otherwise it is random.
  // abort_at>0 asserts rst during that cycle and ends the scenario there.
  task automatic run_stream(input int n, input logic [31:0] ci, input logic [31:0] cq,
                            input bit hold, input int abort_at);
    int total, cnt, k;
    bit in_sym, e_rdy, e_und, v, r;
    logic [31:0] e_mod;
    logic [3:0] s;
    total = 16 * n + 4;
    cycle(1'b0, 1'b1, sym_list[0], ci, cq, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int j = 1; j <= total; j++) begin
      in_sym = (j <= 16 * n);
      cnt    = (j - 1) % 16;
      k      = (j - 1) / 16;
      e_rdy  = in_sym ? (cnt == 15) : 1'b1;
      e_und  = (j == 16 * n + 1);
      e_mod  = (j - 2 >= 1 && j - 2 <= 16 * n) ? {m_list[(j - 3) / 16], 16'h0000} : 32'h0;
      s      = 4'($urandom);
      if (e_rdy) begin
        if (in_sym && k + 1 < n) begin
          v = 1'b1;
          s = sym_list[k + 1];
        end else begin
          v = 1'b0;
        end
      end else begin
        v = hold ? 1'b1 : 1'($urandom);
      end
      r = (j == abort_at);
      cycle(r, v, s, ci, cq, e_rdy && !r, in_sym, e_und, e_mod);
      if (r) return;
    end
  endtask

  initial begin
    rst       = 1'b1;
    sym_valid = 1'b0;
    sym_data  = 4'h0;
    carrier_i = 32'h0;
    carrier_q = 32'h0;
    @(posedge clk);

    // Reset held with random inputs, then released.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'($urandom), 4'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Single symbol 1010, ci = 0x1000, cq = 0.
    sym_list = '{4'b1010};
`ifdef QAM_GRAY_MAP_EN
    m_list = '{16'h0600};
`else
    m_list = '{16'h0200};
`endif
    run_stream(1, 32'h1000_0000, 32'h0000_0000, 1'b0, 0);

    // Extremes: ci = 0x7FFF, cq = 0x8000; low carrier bits are junk.
    sym_list = '{4'b0000, 4'b1010};
`ifdef QAM_GRAY_MAP_EN
    m_list = '{16'hA000, 16'h5FFF};
`else
    m_list = '{16'hA000, 16'h1FFF};
`endif
    run_stream(2, 32'h7FFF_1234, 32'h8000_ABCD, 1'b0, 0);

    // Streaming 10 symbols, valid held high; ci = 0x1000, cq = 0x0800.
    sym_list = '{4'b0000, 4'b0101, 4'b1111, 4'b1010, 4'b0011,
                 4'b1100, 4'b0110, 4'b1001, 4'b0111, 4'b1101};
`ifdef QAM_GRAY_MAP_EN
    m_list = '{16'hFD00, 16'hFF00, 16'h0100, 16'h0300, 16'hF900,
               16'h0500, 16'hFB00, 16'h0700, 16'hFD00, 16'h0300};
`else
    m_list = '{16'hFD00, 16'hFF00, 16'h0300, 16'h0100, 16'hF700,
               16'h0900, 16'hFD00, 16'h0300, 16'hFB00, 16'h0700};
`endif
    run_stream(10, 32'h1000_0000, 32'h0800_0000, 1'b1, 0);

    // Stall: the previous stream dropped valid for 5 cycles at its end;
    // this one is offered straight from IDLE.
    sym_list = '{4'b1100, 4'b0011};
`ifdef QAM_GRAY_MAP_EN
    m_list = '{16'h0500, 16'hF900};
`else
    m_list = '{16'h0900, 16'hF700};
`endif
    run_stream(2, 32'h1000_0000, 32'h0800_0000, 1'b0, 0);

    // Reset during cnt = 7, then a full symbol.
    sym_list = '{4'b1111};
`ifdef QAM_GRAY_MAP_EN
    m_list = '{16'h0100};
`else
    m_list = '{16'h0300};
`endif
    run_stream(1, 32'h1000_0000, 32'h0800_0000, 1'b0, 8);
    sym_list = '{4'b1001};
`ifdef QAM_GRAY_MAP_EN
    m_list = '{16'h0700};
`else
    m_list = '{16'h0300};
`endif
    run_stream(1, 32'h1000_0000, 32'h0800_0000, 1'b0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, expected test to end before it");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
